// File: rtl/spi_pkg.sv
// Shared SPI definitions: mode encodings, sample-edge helper and default word width.
package spi_pkg;

    localparam int unsigned SPI_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        SPI_MODE0 = 2'b00,
        SPI_MODE1 = 2'b01,
        SPI_MODE2 = 2'b10,
        SPI_MODE3 = 2'b11
    } spi_mode_e;

    // Modes 0 and 3 sample on the rising sclk edge, modes 1 and 2 on the falling edge.
    function automatic logic sample_on_rise(input logic [1:0] mode);
        return (spi_mode_e'(mode) == SPI_MODE0) || (spi_mode_e'(mode) == SPI_MODE3);
    endfunction

endpackage

// File: rtl/spi_bit_counter.sv
// Wrapping SPI bit counter clocked on the sample edge; clr_n clears it asynchronously.
module spi_bit_counter
    import spi_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = SPI_DATA_WIDTH,
    parameter int unsigned CW         = $clog2(DATA_WIDTH)
) (
    input  logic          clk,
    input  logic          clr_n,
    output logic [CW-1:0] bit_cnt,
    output logic          last
);

    assign last = (bit_cnt == CW'(DATA_WIDTH - 1));

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            bit_cnt <= '0;
        end else if (last) begin
            bit_cnt <= '0;
        end else begin
            bit_cnt <= bit_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/spi_slave_param.sv
// Parametrised SPI slave (all CPOL/CPHA modes, MSB/LSB first, back-to-back words).
// Optional transmit holding buffer enabled by defining SPI_SLAVE_TXBUF_EN.
module spi_slave_param
    import spi_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = SPI_DATA_WIDTH,
    parameter bit          LSB_FIRST  = 1'b0
) (
    input  logic                  sclk,
    input  logic                  reset,
    input  logic [1:0]            mode,
    input  logic [DATA_WIDTH-1:0] externalin,
    input  logic                  load_enable,
    input  logic                  ss,
    input  logic                  mosi,
    output logic                  miso,
    output logic [DATA_WIDTH-1:0] slave_data,
    output logic                  rx_valid,
    output logic                  busy
);

    localparam int unsigned CW = $clog2(DATA_WIDTH);

    logic                  sample_clk;
    logic                  clr_n;
    logic [CW-1:0]         bit_cnt;
    logic                  cnt_last;
    logic                  mosi_q;
    logic                  pend_req, pend_ack, pend;
    logic                  wd_req, wd_ack, wdone;
    logic                  tx_bit;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [DATA_WIDTH-1:0] shifted;
    logic [DATA_WIDTH-1:0] post_shift;
`ifdef SPI_SLAVE_TXBUF_EN
    logic [DATA_WIDTH-1:0] tx_hold;
    logic                  hold_full;
`endif

    // Posedge of sample_clk is the sample edge, negedge the launch edge, in every mode.
    assign sample_clk = sclk ^ ~sample_on_rise(mode);
    assign clr_n      = reset & ~ss;

    // pend/wdone are set on the sample edge and cleared on the launch edge, so each is
    // split into a req/ack flop pair (one per edge) and reads as req != ack.
    assign pend  = pend_req ^ pend_ack;
    assign wdone = wd_req ^ wd_ack;
    assign busy  = (bit_cnt != '0);
    assign miso  = ss ? 1'b0 : tx_bit;

    generate
        if (LSB_FIRST) begin : g_lsb
            assign tx_bit  = shift_reg[0];
            assign shifted = {mosi_q, shift_reg[DATA_WIDTH-1:1]};
        end else begin : g_msb
            assign tx_bit  = shift_reg[DATA_WIDTH-1];
            assign shifted = {shift_reg[DATA_WIDTH-2:0], mosi_q};
        end
    endgenerate

    assign post_shift = pend ? shifted : shift_reg;

    spi_bit_counter #(
        .DATA_WIDTH (DATA_WIDTH),
        .CW         (CW)
    ) u_bit_counter (
        .clk     (sample_clk),
        .clr_n   (clr_n),
        .bit_cnt (bit_cnt),
        .last    (cnt_last)
    );

    always_ff @(posedge sample_clk or negedge reset) begin
        if (!reset) begin
            mosi_q <= 1'b0;
        end else if (!ss) begin
            mosi_q <= mosi;
        end
    end

    always_ff @(posedge sample_clk or negedge clr_n) begin
        if (!clr_n) begin
            pend_req <= 1'b0;
            wd_req   <= 1'b0;
        end else begin
            pend_req <= ~pend_ack;
            if (cnt_last) begin
                wd_req <= ~wd_ack;
            end
        end
    end

    always_ff @(negedge sample_clk or negedge clr_n) begin
        if (!clr_n) begin
            pend_ack <= 1'b0;
            wd_ack   <= 1'b0;
        end else begin
            pend_ack <= pend_req;
            wd_ack   <= wd_req;
        end
    end

    always_ff @(negedge sample_clk or negedge reset) begin
        if (!reset) begin
            shift_reg  <= '0;
            slave_data <= '0;
            rx_valid   <= 1'b0;
`ifdef SPI_SLAVE_TXBUF_EN
            tx_hold    <= '0;
            hold_full  <= 1'b0;
`endif
        end else begin
            rx_valid <= 1'b0;
            if (load_enable && !busy && !pend) begin
                shift_reg <= externalin;
            end else if (pend) begin
                shift_reg <= shifted;
            end
`ifdef SPI_SLAVE_TXBUF_EN
            if (load_enable && busy) begin
                tx_hold   <= externalin;
                hold_full <= 1'b1;
            end
`endif
            if (wdone) begin
                slave_data <= post_shift;
                rx_valid   <= 1'b1;
`ifdef SPI_SLAVE_TXBUF_EN
                if (hold_full) begin
                    shift_reg <= tx_hold;
                    hold_full <= 1'b0;
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_param.sv
// Directed bench for spi_slave_param: 8-bit MSB-first and 16-bit LSB-first instances.
module tb_spi_slave_param;

    logic        sclk;
    logic        reset;
    logic [1:0]  mode;
    logic [15:0] ext16;
    logic        load_enable;
    logic        ss;
    logic        mosi;
    logic        miso8, miso16;
    logic [7:0]  sd8;
    logic [15:0] sd16;
    logic        rxv8, rxv16;
    logic        busy8, busy16;

    int tests = 0;
    int fails = 0;
    int rxv8_cnt = 0;
    int cnt0;
    logic [15:0] rxw, ra, rb, rc;
    logic [7:0]  exp_w2;

    spi_slave_param #(.DATA_WIDTH(8), .LSB_FIRST(1'b0)) dut8 (
        .sclk        (sclk),
        .reset       (reset),
        .mode        (mode),
        .externalin  (ext16[7:0]),
        .load_enable (load_enable),
        .ss          (ss),
        .mosi        (mosi),
        .miso        (miso8),
        .slave_data  (sd8),
        .rx_valid    (rxv8),
        .busy        (busy8)
    );

    spi_slave_param #(.DATA_WIDTH(16), .LSB_FIRST(1'b1)) dut16 (
        .sclk        (sclk),
        .reset       (reset),
        .mode        (mode),
        .externalin  (ext16),
        .load_enable (load_enable),
        .ss          (ss),
        .mosi        (mosi),
        .miso        (miso16),
        .slave_data  (sd16),
        .rx_valid    (rxv16),
        .busy        (busy16)
    );

    always @(posedge rxv8) rxv8_cnt++;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task lead();
        sclk = ~mode[1];
        #5;
    endtask

    task trail();
        sclk = mode[1];
        #5;
    endtask

    task set_mode(input logic [1:0] m);
        mode = m;
        sclk = m[1];
        #5;
    endtask

    task do_reset();
        reset = 1'b0;
        #5;
        reset = 1'b1;
        #5;
    endtask

    task load(input logic [15:0] v);
        ext16 = v;
        load_enable = 1'b1;
        #2;
        lead();
        trail();
        load_enable = 1'b0;
    endtask

    // Master side: shifts n bits of w out on mosi and collects miso at each sample edge.
    task automatic xfer_bits(input int n, input logic [15:0] w, input bit lsb,
                             input bit sel16, output logic [15:0] r);
        int idx;
        r = '0;
        for (int i = 0; i < n; i++) begin
            idx = lsb ? i : n - 1 - i;
            if (!mode[0]) begin
                mosi = w[idx];
                #5;
                r[idx] = sel16 ? miso16 : miso8;
                lead();
                trail();
            end else begin
                lead();
                mosi = w[idx];
                #2;
                r[idx] = sel16 ? miso16 : miso8;
                trail();
            end
        end
    endtask

    // CPHA=1 needs one more launch edge to commit the last word before ss rises.
    task end_frame();
        if (mode[0]) begin
            lead();
            ss = 1'b1;
            trail();
        end else begin
            ss = 1'b1;
            #5;
        end
    endtask

    initial begin
        sclk = 1'b0; reset = 1'b1; mode = 2'b00; ext16 = '0;
        load_enable = 1'b0; ss = 1'b1; mosi = 1'b0;

        // Reset with ss low and sclk running
        set_mode(2'b00);
        ss = 1'b0;
        reset = 1'b0;
        repeat (4) begin lead(); trail(); end
        chk("rst_slave_data", {8'h00, sd8}, 16'h0000);
        chk("rst_miso", {15'd0, miso8}, 16'h0000);
        chk("rst_rx_valid", {15'd0, rxv8}, 16'h0000);
        chk("rst_busy", {15'd0, busy8}, 16'h0000);
        reset = 1'b1;
        ss = 1'b1;
        #5;

        // Same exchange in all four modes: slave sends DA, master sends 36
        for (int m = 0; m < 4; m++) begin
            set_mode(m[1:0]);
            do_reset();
            load(16'h00DA);
            ss = 1'b0;
            #5;
            chk($sformatf("m%0d_miso_first", m), {15'd0, miso8}, 16'h0001);
            cnt0 = rxv8_cnt;
            xfer_bits(8, 16'h0036, 1'b0, 1'b0, rxw);
            end_frame();
            chk($sformatf("m%0d_slave_data", m), {8'h00, sd8}, 16'h0036);
            chk($sformatf("m%0d_master_rx", m), {8'h00, rxw[7:0]}, 16'h00DA);
            chk($sformatf("m%0d_rx_valid", m), {15'd0, rxv8}, 16'h0001);
            chk($sformatf("m%0d_rxv_pulses", m), 16'(rxv8_cnt - cnt0), 16'd1);
        end

        // Abort after 3 bits of FF, then a clean frame
        set_mode(2'b00);
        cnt0 = rxv8_cnt;
        ss = 1'b0;
        xfer_bits(3, 16'h0007, 1'b0, 1'b0, rxw);
        chk("abort_busy_mid", {15'd0, busy8}, 16'h0001);
        ss = 1'b1;
        #5;
        chk("abort_busy", {15'd0, busy8}, 16'h0000);
        chk("abort_slave_data", {8'h00, sd8}, 16'h0036);
        chk("abort_rx_valid", {15'd0, rxv8}, 16'h0000);
        chk("abort_no_pulse", 16'(rxv8_cnt - cnt0), 16'd0);
        load(16'h00A5);
        ss = 1'b0;
        #5;
        xfer_bits(8, 16'h00C3, 1'b0, 1'b0, rxw);
        end_frame();
        chk("after_abort_slave_data", {8'h00, sd8}, 16'h00C3);
        chk("after_abort_master_rx", {8'h00, rxw[7:0]}, 16'h00A5);

        // 16-bit LSB-first instance
        do_reset();
        load(16'hA5C3);
        ss = 1'b0;
        #5;
        chk("lsb_miso_first", {15'd0, miso16}, 16'h0001);
        xfer_bits(16, 16'h1234, 1'b1, 1'b1, rxw);
        end_frame();
        chk("lsb_slave_data", sd16, 16'h1234);
        chk("lsb_master_rx", rxw, 16'hA5C3);
        chk("lsb_rx_valid", {15'd0, rxv16}, 16'h0001);

        // Back-to-back words; 3C offered mid-word 1
        do_reset();
        load(16'h00DA);
        cnt0 = rxv8_cnt;
        ss = 1'b0;
        #5;
        xfer_bits(4, 16'h0003, 1'b0, 1'b0, ra);
        ext16 = 16'h003C;
        load_enable = 1'b1;
        xfer_bits(1, 16'h0000, 1'b0, 1'b0, rb);
        load_enable = 1'b0;
        xfer_bits(3, 16'h0006, 1'b0, 1'b0, rc);
        chk("b2b_w1_master_rx", {8'h00, ra[3:0], rb[0], rc[2:0]}, 16'h00DA);
        chk("b2b_w1_slave_data", {8'h00, sd8}, 16'h0036);
        chk("b2b_w1_rx_valid", {15'd0, rxv8}, 16'h0001);
`ifdef SPI_SLAVE_TXBUF_EN
        exp_w2 = 8'h3C;
`else
        exp_w2 = 8'h36;
`endif
        xfer_bits(8, 16'h005B, 1'b0, 1'b0, rxw);
        end_frame();
        chk("b2b_w2_master_rx", {8'h00, rxw[7:0]}, {8'h00, exp_w2});
        chk("b2b_w2_slave_data", {8'h00, sd8}, 16'h005B);
        chk("b2b_rxv_pulses", 16'(rxv8_cnt - cnt0), 16'd2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
